sram_controller: RTL and testbench

Responder for the MEM stage's data-memory interface. It accepts one 32-bit word read or write per request from the pipeline and serves it from an external 16-bit asynchronous SRAM as two halfword accesses. While a request is pending it holds `ready` low, and the pipeline uses that signal as a freeze. It sits between the MEM stage and the board SRAM pins, in place of the on-chip data memory.

---
 rtl/sram_controller_pkg.sv | 17 +
 rtl/sram_wait_counter.sv | 31 +++
 rtl/sram_controller.sv | 115 +++++++++++
 tb/tb_sram_controller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// Shared constants and state encoding for the SRAM data-memory responder
// and its helper counter.
package sram_controller_pkg;

  localparam int SRAM_ADDR_LEN    = 18;
  localparam int SRAM_DATA_LEN    = 16;
  localparam int SRAM_ADDR_OFFSET = 1024;
  localparam int WAIT_W           = 4;

  typedef enum logic [1:0] {
    SRAM_IDLE = 2'd0,
    SRAM_LO   = 2'd1,
    SRAM_HI   = 2'd2,
    SRAM_DONE = 2'd3
  } sram_state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Phase timer: load starts a phase of WAIT_CYCLES clocks, and phase_done
// marks the last clock of that phase.
module sram_wait_counter
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic phase_done
);

  logic [WAIT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= WAIT_W'(WAIT_CYCLES - 1);
    end else if (enable && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign phase_done = (count == '0);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage data memory responder: one 32-bit word per request, served as two
// halfword accesses to an external asynchronous 16-bit SRAM.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int ADDR_OFFSET = SRAM_ADDR_OFFSET,
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_ADDR_W = SRAM_ADDR_LEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [31:0]              address,
  input  logic [31:0]              write_data,
  output logic [31:0]              read_data,
  output logic                     ready,
  output logic [SRAM_ADDR_W-1:0]   sram_addr,
  output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
  input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
  output logic                     sram_dq_oe,
  output logic                     sram_we_n,
  output logic                     sram_oe_n
);

  sram_state_t             state;
  logic                    is_write;
  logic [SRAM_ADDR_W-1:0]  base;
  logic [15:0]             wdata_hi;
  logic [SRAM_ADDR_W-1:0]  req_base;
  logic                    request;
  logic                    phase_done;
  logic                    cnt_load;
  logic                    cnt_enable;

  // Halfword index of the word, bit 0 cleared; byte-lane bits drop out.
  assign req_base = SRAM_ADDR_W'(((address - 32'(ADDR_OFFSET)) >> 2) << 1);
  assign request  = rd_en | wr_en;

  assign cnt_load   = (state == SRAM_IDLE && request) ||
                      (state == SRAM_LO && phase_done);
  assign cnt_enable = (state == SRAM_LO) || (state == SRAM_HI);

  sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .enable     (cnt_enable),
    .phase_done (phase_done)
  );

  // NOTE: default assignment first so no path leaves ready unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    ready = 1'b0;
    case (state)
      SRAM_IDLE: ready = ~request;
      SRAM_DONE: ready = 1'b1;
      default:   ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= SRAM_IDLE;
      is_write    <= 1'b0;
      base        <= '0;
      wdata_hi    <= '0;
      // NOTE: read_data is architecturally visible, so it is reset along
      // with the pad controls rather than left undefined.
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      case (state)
        SRAM_IDLE: begin
          if (request) begin
            // Write wins when both enables are high.
            is_write    <= wr_en;
            base        <= req_base;
            wdata_hi    <= write_data[31:16];
            sram_addr   <= req_base;
            sram_dq_out <= wr_en ? write_data[15:0] : '0;
            sram_dq_oe  <= wr_en;
            sram_we_n   <= ~wr_en;
            sram_oe_n   <= wr_en;
            state       <= SRAM_LO;
          end
        end
        SRAM_LO: begin
          if (phase_done) begin
            if (!is_write) read_data[15:0] <= sram_dq_in;
            sram_addr   <= base | SRAM_ADDR_W'(1);
            sram_dq_out <= is_write ? wdata_hi : '0;
            state       <= SRAM_HI;
          end
        end
        SRAM_HI: begin
          if (phase_done) begin
            if (!is_write) read_data[31:16] <= sram_dq_in;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            state      <= SRAM_DONE;
          end
        end
        default: state <= SRAM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: a W=1 and a W=3 instance, each with a behavioural
// asynchronous SRAM, checked against hand-derived vectors and a scoreboard queue.
module tb_sram_controller;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en      [2];
  logic              rd_en      [2];
  logic [31:0]       address    [2];
  logic [31:0]       write_data [2];
  logic [31:0]       read_data  [2];
  logic              ready      [2];
  logic [17:0]       sram_addr  [2];
  logic [15:0]       dq_out     [2];
  logic [15:0]       dq_in      [2];
  logic              dq_oe      [2];
  logic              we_n       [2];
  logic              oe_n       [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [15:0] mem [64];

    sram_controller #(
      .ADDR_OFFSET (1024),
      .WAIT_CYCLES (g == 0 ? 1 : 3),
      .SRAM_ADDR_W (18)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en[g]),
      .rd_en       (rd_en[g]),
      .address     (address[g]),
      .write_data  (write_data[g]),
      .read_data   (read_data[g]),
      .ready       (ready[g]),
      .sram_addr   (sram_addr[g]),
      .sram_dq_out (dq_out[g]),
      .sram_dq_in  (dq_in[g]),
      .sram_dq_oe  (dq_oe[g]),
      .sram_we_n   (we_n[g]),
      .sram_oe_n   (oe_n[g])
    );

    always @(posedge clk) if (!we_n[g]) mem[sram_addr[g][5:0]] <= dq_out[g];
    assign dq_in[g] = oe_n[g] ? 16'hdead : mem[sram_addr[g][5:0]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [17:0] addr_log  [64];
  logic [15:0] dq_log    [64];
  logic        we_log    [64];
  logic        oe_log    [64];
  logic        dqoe_log  [64];
  logic        ready_log [64];
  int          we_cnt;
  int          oe_cnt;

  logic [31:0] sb [$];

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one request in an IDLE cycle, logs pad activity each cycle until
  // ready (bounded), drops the enables and steps back into IDLE.
  task automatic access(input int s, input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, output int lat);
    @(negedge clk);
    wr_en[s] = w; rd_en[s] = r; address[s] = a; write_data[s] = d;
    #1;
    check("request_stalls", ready[s], 1'b0);
    lat = 0; we_cnt = 0; oe_cnt = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      addr_log[lat] = sram_addr[s]; dq_log[lat] = dq_out[s];
      we_log[lat] = we_n[s]; oe_log[lat] = oe_n[s];
      dqoe_log[lat] = dq_oe[s]; ready_log[lat] = ready[s];
      if (!we_n[s]) we_cnt++;
      if (!oe_n[s]) oe_cnt++;
    end while (!ready[s] && lat < 40);
    check("access_completes", ready[s], 1'b1);
    wr_en[s] = 1'b0; rd_en[s] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int n;
    logic [31:0] exp;

    vecs[0] = '{1'b1, 1'b0, 32'd1028, 32'hdeadbeef, 32'h12345678};
    vecs[1] = '{1'b1, 1'b0, 32'd1100, 32'ha5a55a5a, 32'h12345678};
    vecs[2] = '{1'b0, 1'b1, 32'd1028, 32'h0,        32'hdeadbeef};
    vecs[3] = '{1'b0, 1'b1, 32'd1100, 32'h0,        32'ha5a55a5a};
    vecs[4] = '{1'b1, 1'b1, 32'd1028, 32'h0badf00d, 32'ha5a55a5a};
    vecs[5] = '{1'b0, 1'b1, 32'd1028, 32'h0,        32'h0badf00d};
    vecs[6] = '{1'b1, 1'b0, 32'd1035, 32'h13579bdf, 32'h0badf00d};
    vecs[7] = '{1'b0, 1'b1, 32'd1032, 32'h0,        32'h13579bdf};

    for (int s = 0; s < 2; s++) begin
      wr_en[s] = 1'b0; rd_en[s] = 1'b0; address[s] = '0; write_data[s] = '0;
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready",     ready[0],     1'b1);
    check("reset_read_data", read_data[0], 32'h0);
    check("reset_sram_addr", sram_addr[0], 32'h0);
    check("reset_strobes",   {we_n[0], oe_n[0], dq_oe[0]}, 3'b110);
    check("reset_dq_out",    dq_out[0],    32'h0);
    rst = 1'b1;

    // Write 0x12345678 to 1024 with W=1.
    access(0, 1'b1, 1'b0, 32'd1024, 32'h12345678, lat);
    check("wr_latency",  lat, 3);
    check("wr_c1_addr",  addr_log[1], 32'd0);
    check("wr_c1_dq",    dq_log[1], 32'h5678);
    check("wr_c1_we_n",  we_log[1], 1'b0);
    check("wr_c1_dq_oe", dqoe_log[1], 1'b1);
    check("wr_c2_addr",  addr_log[2], 32'd1);
    check("wr_c2_dq",    dq_log[2], 32'h1234);
    check("wr_c2_we_n",  we_log[2], 1'b0);
    check("wr_ready_lo", {ready_log[1], ready_log[2]}, 2'b00);
    check("wr_c3_we_n",  we_log[3], 1'b1);

    // Read it back.
    access(0, 1'b0, 1'b1, 32'd1024, 32'h0, lat);
    check("rd_latency",  lat, 3);
    check("rd_data",     read_data[0], 32'h12345678);
    check("rd_oe_n",     {oe_log[1], oe_log[2]}, 2'b00);
    check("rd_dq_oe",    {dqoe_log[1], dqoe_log[2]}, 2'b00);

    // Table-driven vectors; read_data expectation goes through the scoreboard.
    for (int i = 0; i < 8; i++) begin
      sb.push_back(vecs[i].exp_rd);
      access(0, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, lat);
      check($sformatf("vec%0d_latency", i), lat, 3);
      check($sformatf("vec%0d_we_cycles", i), we_cnt, vecs[i].wr ? 2 : 0);
      check($sformatf("vec%0d_oe_cycles", i), oe_cnt, vecs[i].wr ? 0 : 2);
      exp = sb.pop_front();
      check($sformatf("vec%0d_read_data", i), read_data[0], exp);
    end

    // Request held one extra cycle after ready: two complete accesses.
    @(negedge clk);
    rd_en[0] = 1'b1; address[0] = 32'd1024;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ready[0] && n < 40);
    check("b2b_first_latency", n, 3);
    check("b2b_first_data", read_data[0], 32'h12345678);
    @(posedge clk); #1;
    check("b2b_second_stalls", ready[0], 1'b0);
    @(posedge clk); #1;
    rd_en[0] = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ready[0] && n < 40);
    check("b2b_second_remaining", n, 2);
    check("b2b_second_data", read_data[0], 32'h12345678);
    @(posedge clk); #1;

    // Reset during the HI phase of a read.
    @(negedge clk);
    rd_en[0] = 1'b1; address[0] = 32'd1028;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_hi_addr", sram_addr[0], 32'd3);
    check("mid_hi_oe_n", oe_n[0], 1'b0);
    rst = 1'b0; rd_en[0] = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_read_data", read_data[0], 32'h0);
    check("rst_mid_strobes", {we_n[0], oe_n[0], dq_oe[0]}, 3'b110);
    check("rst_mid_addr", sram_addr[0], 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ready", ready[0], 1'b1);
    check("rst_mid_hold", read_data[0], 32'h0);
    access(0, 1'b0, 1'b1, 32'd1024, 32'h0, lat);
    check("post_rst_latency", lat, 3);
    check("post_rst_data", read_data[0], 32'h12345678);

    // Idle with no enables: never stalls, never strobes.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle%0d", i), {ready[0], we_n[0], oe_n[0], dq_oe[0]}, 4'b1110);
    end

    // W=3 instance: write then read address 1032.
    access(1, 1'b1, 1'b0, 32'd1032, 32'hcafebabe, lat);
    check("w3_wr_latency", lat, 7);
    check("w3_wr_we_cycles", we_cnt, 6);
    access(1, 1'b0, 1'b1, 32'd1032, 32'h0, lat);
    check("w3_rd_latency", lat, 7);
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("w3_c%0d_addr", c), addr_log[c], (c <= 3) ? 32'd4 : 32'd5);
      check($sformatf("w3_c%0d_ready", c), ready_log[c], 1'b0);
    end
    check("w3_c7_ready", ready_log[7], 1'b1);
    check("w3_rd_data", read_data[1], 32'hcafebabe);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
